// File: rtl/renderer_pkg.sv
// Shared definitions for the cell renderer pipeline: cell mode encodings,
// the default palette layout and where the border entry sits in the palette.
package renderer_pkg;

  typedef enum logic [1:0] {
    MODE_EMPTY = 2'd0,
    MODE_X     = 2'd1,
    MODE_O     = 2'd2,
    MODE_WIN   = 2'd3
  } cell_mode_e;

  // Border entry lives at NUM_MODES + BORDER_ADDR_OFS in the palette.
  localparam int BORDER_ADDR_OFS = 0;

  // Default channel mask {R,G,B}; a set bit means that channel resets to all-ones.
  function automatic logic [2:0] default_mask(input int idx);
    logic [2:0] m;
    case (idx)
      int'(MODE_EMPTY): m = 3'b010;
      int'(MODE_X):     m = 3'b100;
      int'(MODE_O):     m = 3'b001;
      int'(MODE_WIN):   m = 3'b110;
      default:          m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/renderer_palette.sv
// Writable colour palette: NUM_MODES cell entries plus one border entry,
// asynchronous-reset write port and a combinational read port (read-before-write).
module renderer_palette
  import renderer_pkg::*;
#(
  parameter int COLOR_W   = 4,
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [MODE_W:0]        waddr,
  input  logic [3*COLOR_W-1:0]   wdata,
  input  logic [MODE_W:0]        raddr,
  output logic [3*COLOR_W-1:0]   rdata
);

  localparam int ENTRIES = NUM_MODES + BORDER_ADDR_OFS + 1;
  localparam int AW      = MODE_W + 1;

  logic [3*COLOR_W-1:0] mem_r [ENTRIES];

  function automatic logic [3*COLOR_W-1:0] reset_value(input int idx);
    logic [COLOR_W-1:0] f;
    logic [COLOR_W-1:0] h;
    logic [2:0]         m;
    f = {COLOR_W{1'b1}};
    h = f ^ (f >> 1);
    m = default_mask(idx);
    if (idx == NUM_MODES + BORDER_ADDR_OFS) begin
      return {h, h, h};
    end else if (idx < NUM_MODES) begin
      return {(m[2] ? f : {COLOR_W{1'b0}}),
              (m[1] ? f : {COLOR_W{1'b0}}),
              (m[0] ? f : {COLOR_W{1'b0}})};
    end else begin
      return {(3*COLOR_W){1'b0}};
    end
  endfunction

  // Register file: addresses beyond the last entry match nothing and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= reset_value(i);
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (we && (waddr == AW'(i))) begin
          mem_r[i] <= wdata;
        end
      end
    end
  end

  // Read mux built as an OR of one-hot selected entries.
  always_comb begin
    rdata = {(3*COLOR_W){1'b0}};
    for (int i = 0; i < ENTRIES; i++) begin
      rdata = rdata | ((raddr == AW'(i)) ? mem_r[i] : {(3*COLOR_W){1'b0}});
    end
  end

endmodule

// File: rtl/cell_renderer_pipe.sv
// Two-stage pixel renderer: palette lookup, highlight inversion and blanking,
// with sync/de aligned to rgb. Define RENDERER_BLINK_EN to blink the highlight.
module cell_renderer_pipe
  import renderer_pkg::*;
#(
  parameter int COLOR_W      = 4,
  parameter int NUM_MODES    = 4,
  parameter int MODE_W       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de,
  input  logic [1:0]           sync_in,
  input  logic                 frame_start,
  input  logic                 cell_hit,
  input  logic [MODE_W-1:0]    cell_mode,
  input  logic                 highlight,
  input  logic                 pal_we,
  input  logic [MODE_W:0]      pal_addr,
  input  logic [3*COLOR_W-1:0] pal_wdata,
  output logic [3*COLOR_W-1:0] rgb,
  output logic [1:0]           sync_out,
  output logic                 de_out
);

  localparam int AW  = MODE_W + 1;
  localparam int CW3 = 3 * COLOR_W;
  localparam logic [AW-1:0] BORDER_ADDR = AW'(NUM_MODES + BORDER_ADDR_OFS);
  localparam logic [AW-1:0] MODE_LIMIT  = AW'(NUM_MODES);

  logic [AW-1:0]  rd_addr_s;
  logic [CW3-1:0] pal_rdata_s;
  logic [CW3-1:0] color_s;
  logic           blink_on_s;
  logic [CW3-1:0] rgb_next_s;

  logic           de_r;
  logic [1:0]     sync_r;
  logic           hl_r;
  logic           hit_r;
  logic [CW3-1:0] color_r;
  logic [CW3-1:0] rgb_r;
  logic [1:0]     sync_out_r;
  logic           de_out_r;

  renderer_palette #(
    .COLOR_W   (COLOR_W),
    .NUM_MODES (NUM_MODES),
    .MODE_W    (MODE_W)
  ) u_palette (
    .clk   (clk),
    .rst   (rst),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_wdata),
    .raddr (rd_addr_s),
    .rdata (pal_rdata_s)
  );

  // Stage-1 colour select; unused mode codes render black.
  always_comb begin
    if (cell_hit) begin
      rd_addr_s = {1'b0, cell_mode};
      color_s   = ({1'b0, cell_mode} >= MODE_LIMIT) ? {CW3{1'b0}} : pal_rdata_s;
    end else begin
      rd_addr_s = BORDER_ADDR;
      color_s   = pal_rdata_s;
    end
  end

  // Stage 1; sync idles high so reset never looks like a sync pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_r    <= 1'b0;
      sync_r  <= 2'b11;
      hl_r    <= 1'b0;
      hit_r   <= 1'b0;
      color_r <= {CW3{1'b0}};
    end else begin
      de_r    <= de;
      sync_r  <= sync_in;
      hl_r    <= highlight;
      hit_r   <= cell_hit;
      color_r <= color_s;
    end
  end

`ifdef RENDERER_BLINK_EN
  localparam int BCW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

  logic [BCW-1:0] blink_cnt_r;
  logic           blink_phase_r;

  // Frame counter toggling the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_r   <= {BCW{1'b0}};
      blink_phase_r <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r   <= {BCW{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + BCW'(1);
      end
    end
  end

  assign blink_on_s = blink_phase_r;
`else
  logic unused_blink_s;
  assign unused_blink_s = frame_start ^ (BLINK_FRAMES > 0);
  assign blink_on_s     = 1'b1;
`endif

  // Stage-2 colour: blanking wins, border pixels are never inverted.
  always_comb begin
    if (!de_r) begin
      rgb_next_s = {CW3{1'b0}};
    end else if (hl_r && hit_r && blink_on_s) begin
      rgb_next_s = ~color_r;
    end else begin
      rgb_next_s = color_r;
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_r      <= {CW3{1'b0}};
      sync_out_r <= 2'b11;
      de_out_r   <= 1'b0;
    end else begin
      rgb_r      <= rgb_next_s;
      sync_out_r <= sync_r;
      de_out_r   <= de_r;
    end
  end

  assign rgb      = rgb_r;
  assign sync_out = sync_out_r;
  assign de_out   = de_out_r;

endmodule

// File: tb/tb_cell_renderer_pipe.sv
// Self-checking bench for cell_renderer_pipe: two instances (4 and 3 modes),
// table vectors, palette/reset/blink sequences and a randomized model check.
module tb_cell_renderer_pipe;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        de;
  logic [1:0]  sync_in;
  logic        frame_start;
  logic        cell_hit;
  logic [1:0]  cell_mode;
  logic        highlight;
  logic        pal_we;
  logic [2:0]  pal_addr;
  logic [11:0] pal_wdata;
  logic [11:0] rgb_a, rgb_b;
  logic [1:0]  sync_out_a, sync_out_b;
  logic        de_out_a, de_out_b;

  always #5 clk = ~clk;

  cell_renderer_pipe #(.COLOR_W(4), .NUM_MODES(4), .MODE_W(2), .BLINK_FRAMES(BF)) dut_a (
    .clk(clk), .rst(rst), .de(de), .sync_in(sync_in), .frame_start(frame_start),
    .cell_hit(cell_hit), .cell_mode(cell_mode), .highlight(highlight),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .rgb(rgb_a), .sync_out(sync_out_a), .de_out(de_out_a)
  );

  cell_renderer_pipe #(.COLOR_W(4), .NUM_MODES(3), .MODE_W(2), .BLINK_FRAMES(BF)) dut_b (
    .clk(clk), .rst(rst), .de(de), .sync_in(sync_in), .frame_start(frame_start),
    .cell_hit(cell_hit), .cell_mode(cell_mode), .highlight(highlight),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .rgb(rgb_b), .sync_out(sync_out_b), .de_out(de_out_b)
  );

  typedef struct {
    logic        de;
    logic [1:0]  sync;
    logic        hit;
    logic [1:0]  mode;
    logic        hl;
    logic [11:0] ea;
    logic [11:0] eb;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        tab_en;
    logic [11:0] ea;
    logic [11:0] eb;
    logic [11:0] ma;
    logic [11:0] mb;
    logic [1:0]  sync;
    logic        de;
  } exp_t;

  vec_t        tab [11];
  exp_t        prev;
  logic [11:0] pal_a [5];
  logic [11:0] pal_b [5];
  int          frames_seen;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    pal_a[0] = 12'h0F0; pal_a[1] = 12'hF00; pal_a[2] = 12'h00F; pal_a[3] = 12'hFF0; pal_a[4] = 12'h888;
    pal_b[0] = 12'h0F0; pal_b[1] = 12'hF00; pal_b[2] = 12'h00F; pal_b[3] = 12'h888; pal_b[4] = 12'h000;
    frames_seen = 0;
    prev.valid  = 1'b0;
  endtask

  function automatic logic blink_on_model(input int fs);
`ifdef RENDERER_BLINK_EN
    return ((fs / BF) % 2) == 0;
`else
    return fs >= 0;
`endif
  endfunction

  function automatic logic [11:0] model_rgb(input int nm, input logic [11:0] pal [5], input logic d,
                                            input logic hit, input logic [1:0] mode, input logic hl,
                                            input logic on);
    logic [11:0] c;
    if (!d) return 12'h000;
    if (!hit) c = pal[nm];
    else if (int'(mode) < nm) c = pal[mode];
    else c = 12'h000;
    if (hl && hit && on) c = ~c;
    return c;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_rgb_a", rgb_a, 12'h000);
    chk("rst_rgb_b", rgb_b, 12'h000);
    chk("rst_sync_a", {10'd0, sync_out_a}, 12'h003);
    chk("rst_sync_b", {10'd0, sync_out_b}, 12'h003);
    chk("rst_de_a", {11'd0, de_out_a}, 12'h000);
    chk("rst_de_b", {11'd0, de_out_b}, 12'h000);
  endtask

  // One pixel: drive at negedge, model it, check the previous pixel after the edge.
  task automatic step(input logic de_i, input logic [1:0] sync_i, input logic hit_i,
                      input logic [1:0] mode_i, input logic hl_i, input logic fs_i,
                      input logic we_i, input logic [2:0] addr_i, input logic [11:0] wd_i,
                      input logic tab_i, input logic [11:0] ea_i, input logic [11:0] eb_i);
    exp_t cur;
    @(negedge clk);
    de = de_i; sync_in = sync_i; cell_hit = hit_i; cell_mode = mode_i; highlight = hl_i;
    frame_start = fs_i; pal_we = we_i; pal_addr = addr_i; pal_wdata = wd_i;
    if (fs_i) frames_seen++;
    cur.valid  = 1'b1;
    cur.tab_en = tab_i;
    cur.ea     = ea_i;
    cur.eb     = eb_i;
    cur.ma     = model_rgb(4, pal_a, de_i, hit_i, mode_i, hl_i, blink_on_model(frames_seen));
    cur.mb     = model_rgb(3, pal_b, de_i, hit_i, mode_i, hl_i, blink_on_model(frames_seen));
    cur.sync   = sync_i;
    cur.de     = de_i;
    if (we_i) begin
      if (addr_i <= 3'd4) pal_a[addr_i] = wd_i;
      if (addr_i <= 3'd3) pal_b[addr_i] = wd_i;
    end
    @(posedge clk);
    #1;
    if (prev.valid) begin
      chk("model_rgb_a", rgb_a, prev.ma);
      chk("model_rgb_b", rgb_b, prev.mb);
      chk("sync_a", {10'd0, sync_out_a}, {10'd0, prev.sync});
      chk("sync_b", {10'd0, sync_out_b}, {10'd0, prev.sync});
      chk("de_a", {11'd0, de_out_a}, {11'd0, prev.de});
      chk("de_b", {11'd0, de_out_b}, {11'd0, prev.de});
      if (prev.tab_en) begin
        chk("const_rgb_a", rgb_a, prev.ea);
        chk("const_rgb_b", rgb_b, prev.eb);
      end
    end
    prev = cur;
  endtask

  task automatic idle_step();
    step(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 12'h000, 12'h000);
  endtask

  initial begin
    tab[0]  = '{1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 12'hF00, 12'hF00};
    tab[1]  = '{1'b1, 2'b10, 1'b1, 2'd0, 1'b0, 12'h0F0, 12'h0F0};
    tab[2]  = '{1'b1, 2'b11, 1'b1, 2'd2, 1'b0, 12'h00F, 12'h00F};
    tab[3]  = '{1'b1, 2'b00, 1'b1, 2'd3, 1'b0, 12'hFF0, 12'h000};
    tab[4]  = '{1'b1, 2'b01, 1'b0, 2'd2, 1'b0, 12'h888, 12'h888};
    tab[5]  = '{1'b0, 2'b10, 1'b1, 2'd1, 1'b0, 12'h000, 12'h000};
    tab[6]  = '{1'b1, 2'b11, 1'b1, 2'd2, 1'b1, 12'hFF0, 12'hFF0};
    tab[7]  = '{1'b1, 2'b00, 1'b0, 2'd1, 1'b1, 12'h888, 12'h888};
    tab[8]  = '{1'b1, 2'b01, 1'b1, 2'd3, 1'b1, 12'h00F, 12'hFFF};
    tab[9]  = '{1'b1, 2'b10, 1'b1, 2'd0, 1'b1, 12'hF0F, 12'hF0F};
    tab[10] = '{1'b0, 2'b00, 1'b1, 2'd3, 1'b1, 12'h000, 12'h000};

    rst = 1'b0; de = 1'b0; sync_in = 2'b11; frame_start = 1'b0; cell_hit = 1'b0;
    cell_mode = 2'd0; highlight = 1'b0; pal_we = 1'b0; pal_addr = 3'd0; pal_wdata = 12'h000;
    reset_model();
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Constant-expectation vectors.
    for (int i = 0; i < 11; i++) begin
      step(tab[i].de, tab[i].sync, tab[i].hit, tab[i].mode, tab[i].hl, 1'b0, 1'b0, 3'd0,
           12'h000, 1'b1, tab[i].ea, tab[i].eb);
    end
    idle_step();

    // Same-cycle write/read returns the old value, next cycle the new one.
    step(1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 12'h5A3, 1'b1, 12'hF00, 12'hF00);
    step(1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 12'h5A3, 12'h5A3);
    // Out-of-range address changes nothing; addr 4 is border of A only, addr 3 border of B.
    step(1'b0, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd5, 12'h123, 1'b0, 12'h000, 12'h000);
    step(1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd4, 12'h456, 1'b1, 12'h888, 12'h888);
    step(1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd3, 12'h789, 1'b1, 12'h456, 12'h888);
    step(1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 12'h456, 12'h789);
    step(1'b1, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 12'h789, 12'h000);
    for (int m = 0; m < 4; m++) begin
      step(1'b1, 2'b01, 1'b1, 2'(m), 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 12'h000, 12'h000);
    end
    idle_step();

    // Asynchronous reset mid-frame.
    step(1'b1, 2'b00, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 12'h000, 12'h000);
    step(1'b1, 2'b00, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 12'h000, 12'h000);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    reset_model();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 12'hF00, 12'hF00);
    step(1'b1, 2'b01, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1, 12'h00F, 12'h00F);
    idle_step();

`ifdef RENDERER_BLINK_EN
    // Blink with BLINK_FRAMES=2: frames 0-1 inverted, 2-3 plain, 4-5 inverted.
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 4; p++) begin
        step(1'b1, 2'b01, 1'b1, 2'd0, 1'b1, (f > 0) && (p == 0), 1'b0, 3'd0, 12'h000, 1'b1,
             ((f / 2) % 2 == 0) ? 12'hF0F : 12'h0F0, ((f / 2) % 2 == 0) ? 12'hF0F : 12'h0F0);
      end
    end
    idle_step();
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), 12'($urandom), 1'b0,
           12'h000, 12'h000);
    end
    idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cell_renderer_pipe.md
Name: cell_renderer_pipe

Overview:
- Parametrised, pipelined successor to the board pixel renderer.
- Converts per-pixel cell-hit/mode/highlight/blanking info from the VGA timing and board-geometry logic into registered RGB.
- Adds a writable colour palette, N-bit channels, sync pass-through alignment and frame-based highlight blinking.
- Sits between the board-geometry decoder and the VGA output pins.

Parameters:
COLOR_W, 4, bits per colour channel
NUM_MODES, 4, number of cell modes (palette entries for cells)
MODE_W, 2, width of cell_mode; NUM_MODES <= 2**MODE_W
BLINK_FRAMES, 30, frames per blink half-period (used only with BLINK_EN)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
de  in  1  display enable (1 = active video, 0 = blanking)
sync_in  in  2  {vsync, hsync} from timing generator
frame_start  in  1  one-cycle pulse at first pixel of each frame
cell_hit  in  1  1 = pixel inside a cell, 0 = pixel on grid border
cell_mode  in  MODE_W  mode of the cell under the pixel
highlight  in  1  pixel belongs to the cursor cell
pal_we  in  1  palette write strobe
pal_addr  in  MODE_W+1  palette entry; 0..NUM_MODES-1 = cells, NUM_MODES = border
pal_wdata  in  3*COLOR_W  {R,G,B} write data
rgb  out  3*COLOR_W  {R,G,B} pixel colour
sync_out  out  2  sync_in delayed to match rgb
de_out  out  1  de delayed to match rgb

Behaviour:
- Reset (rst=0, asynchronous): rgb=0, sync_out=2'b11, de_out=0, all pipeline registers cleared, blink counter=0, blink_phase=1.
- Palette reset values, where F = all-ones COLOR_W and H = MSB-only COLOR_W:
  - entry 0 = {0,F,0}
  - entry 1 = {F,0,0}
  - entry 2 = {0,0,F}
  - entry 3 = {F,F,0}
  - entries 4..NUM_MODES-1 = 0
  - border entry = {H,H,H}
- Latency: fixed 2 cycles from inputs to rgb/sync_out/de_out, including during blanking.
- Stage 1 (registered):
  - Registers de, sync_in, highlight.
  - Palette colour = entry[cell_mode] if cell_hit, else border entry.
  - cell_mode >= NUM_MODES selects black.
- Stage 2 (registered):
  - If stage-1 de=0: rgb=0.
  - Else, if stage-1 highlight && cell_hit && blink_on: rgb = bitwise inverse of palette colour.
  - Else: rgb = palette colour.
  - The border is never inverted.
- Palette write:
  - pal_we=1 writes pal_wdata at pal_addr on the rising edge.
  - pal_addr > NUM_MODES is ignored.
  - Read and write of the same entry in the same cycle: the read returns the old value; the new value is visible to stage 1 on the next cycle.
  - Writes are accepted regardless of de.
- Blink:
  - On each frame_start, counter increments.
  - At BLINK_FRAMES-1 the counter wraps to 0 and toggles blink_phase.
  - blink_on = blink_phase.
  - frame_start is ignored on cycles where rst is asserted.
- Inputs that change during blanking produce rgb=0; sync_out still tracks sync_in with 2-cycle delay.

Optional Feature:
- Macro: RENDERER_BLINK_EN.
- Defined: highlight inversion applies only while blink_phase=1 (toggles every BLINK_FRAMES frames).
- Undefined: blink counter/phase are not built; blink_on is constant 1, so highlight is always inverted; frame_start is unused.

Decomposition:
- Shared package/header renderer_pkg holds:
  - mode encodings (MODE_EMPTY=0, MODE_X=1, MODE_O=2, MODE_WIN=3);
  - default palette constants;
  - border address offset.
- One sub-module is natural: renderer_palette, a (NUM_MODES+1)-entry register file with an async-reset write port and a combinational read port.

Test Plan:
- Reset: rst=0 mid-frame → rgb=0, sync_out=11, de_out=0 immediately. Release, then de=1, cell_hit=1, mode=1 → rgb=12'hF00 after 2 clocks.
- Modes and border (COLOR_W=4): mode=0,2,3 → 0F0,00F,FF0; cell_hit=0 → 888; de=0 → 000 with sync_out equal to sync_in delayed 2 cycles.
- Highlight: mode=2, highlight=1 → FF0. Border pixel with highlight=1 → 888.
- Palette: write addr=1 data=12'h5A3, same-cycle read of mode 1 → F00; next cycle → 5A3. Write addr=5 (NUM_MODES=4, out of range) → no entry changes.
- Blink (RENDERER_BLINK_EN, BLINK_FRAMES=2), highlight=1 mode=0:
  - frames 0–1 → F0F;
  - frames 2–3 → 0F0;
  - frames 4–5 → F0F.
- Out-of-range mode: NUM_MODES=3, MODE_W=2, mode=3 → rgb=000; with highlight → FFF.
